// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: iterative AES InvMixColumns stage with valid/ready handshake.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready/state_in/bypass accept a 128-bit
// state (column c at [127-32c -: 32], row 0 in the MSByte); out_valid/out_ready/state_out
// present the result; busy is high while a state is held (RUN or DONE).

// inv_mix_column_helper: InvMixColumns on one 32-bit column, row 0 in the MSByte.
module inv_mix_column_helper (
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  logic [7:0] a [4];
  logic [7:0] m9 [4], mb [4], md [4], me [4];
  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [7:0] x2, x4, x8;
    assign a[r]  = col_in[31-8*r -: 8];
    assign x2    = xt(a[r]);
    assign x4    = xt(x2);
    assign x8    = xt(x4);
    assign m9[r] = x8 ^ a[r];
    assign mb[r] = x8 ^ x2 ^ a[r];
    assign md[r] = x8 ^ x4 ^ a[r];
    assign me[r] = x8 ^ x4 ^ x2;
  end
  for (genvar r = 0; r < 4; r++) begin : g_out
    assign col_out[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
  end
endmodule

module inv_mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);
  localparam int GROUPS = 4 / COLS_PER_CYCLE;
  localparam int W = 32 * COLS_PER_CYCLE;
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d, res_q, res_d;
  logic [6:0]   base;
  logic [W-1:0] grp_in, grp_out;
  // Group k holds columns k*COLS_PER_CYCLE.., column 0 being the most significant word.
  assign base   = 7'(W * (GROUPS - 1 - int'(cnt_q)));
  assign grp_in = work_q[base +: W];
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_helper
    inv_mix_column_helper u_helper (
      .col_in (grp_in[W-1-32*j -: 32]),
      .col_out(grp_out[W-1-32*j -: 32])
    );
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (in_valid) begin
        work_d  = state_in;
        cnt_d   = 2'd0;
        res_d   = bypass ? state_in : res_q;
        state_d = bypass ? DONE : RUN;
      end
      RUN: begin
        res_d[base +: W] = grp_out;
        state_d = (cnt_q == 2'(GROUPS - 1)) ? DONE : RUN;
        cnt_d   = (cnt_q == 2'(GROUPS - 1)) ? cnt_q : cnt_q + 2'd1;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      work_q  <= 128'h0;
      res_q   <= 128'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      res_q   <= res_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign state_out = res_q;
endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb_inv_mix_columns_iter: randomized self-checking bench for COLS_PER_CYCLE = 1, 2, 4.
module tb_inv_mix_columns_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic         iv [3], ir [3], byp [3], ov [3], ordy [3], bsy [3];
  logic [127:0] sin [3], sout [3];
  int checks = 0, errors = 0;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]), .state_in(sin[g]),
      .bypass(byp[g]), .out_valid(ov[g]), .out_ready(ordy[g]), .state_out(sout[g]), .busy(bsy[g])
    );
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction
  // Reference: each output byte is a row of the circulant matrix (0e 0b 0d 09) times the column.
  function automatic logic [127:0] model(input logic [127:0] s, input logic bp);
    logic [7:0] k [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [7:0] a [4];
    logic [7:0] acc;
    logic [127:0] o = 128'h0;
    if (bp) return s;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc ^= gmul(a[(r+j)%4], k[j]);
        o[127-32*c-8*r -: 8] = acc;
      end
    end
    return o;
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  function automatic int exp_lat(input int i, input logic bp);
    return bp ? 1 : 4 / (1 << i) + 1;
  endfunction
  task automatic wait_ready(input int i, input string tag);
    int n = 0;
    while (!ir[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready"}, 128'(ir[i]), 128'(1));
  endtask
  task automatic wait_out(input int i, input string tag, input int lat_exp, input logic [127:0] exp);
    int lat = 1;
    while (!ov[i] && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(lat_exp));
    chk({tag, "_data"}, sout[i], exp);
  endtask
  task automatic txn(input int i, input logic [127:0] d, input logic bp, input int stall,
                     input logic [127:0] exp, input string tag);
    logic [127:0] held;
    @(negedge clk);
    iv[i] = 1'b1; sin[i] = d; byp[i] = bp; ordy[i] = (stall == 0);
    wait_ready(i, tag);
    @(posedge clk);
    #1;
    iv[i] = 1'b0; sin[i] = rnd128();
    wait_out(i, tag, exp_lat(i, bp), exp);
    held = sout[i];
    for (int s = 0; s < stall; s++) begin
      iv[i] = 1'b1; sin[i] = rnd128(); byp[i] = 1'(s);
      @(posedge clk);
      #1;
      chk({tag, "_stall_valid"}, 128'(ov[i]), 128'(1));
      chk({tag, "_stall_data"}, sout[i], held);
      chk({tag, "_stall_in_ready"}, 128'(ir[i]), 128'(0));
    end
    iv[i] = 1'b0; ordy[i] = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_drop_valid"}, 128'(ov[i]), 128'(0));
    chk({tag, "_idle_ready"}, 128'(ir[i]), 128'(1));
    chk({tag, "_idle_busy"}, 128'(bsy[i]), 128'(0));
  endtask
  task automatic b2b(input int i, input logic [127:0] d0, input logic [127:0] d1);
    @(negedge clk);
    iv[i] = 1'b1; sin[i] = d0; byp[i] = 1'b0; ordy[i] = 1'b1;
    wait_ready(i, "b2b0");
    @(posedge clk);
    #1;
    sin[i] = d1;
    wait_out(i, "b2b0", exp_lat(i, 1'b0), model(d0, 1'b0));
    @(posedge clk);
    #1;
    chk("b2b_gap_valid", 128'(ov[i]), 128'(0));
    chk("b2b_gap_ready", 128'(ir[i]), 128'(1));
    @(posedge clk);
    #1;
    iv[i] = 1'b0; sin[i] = rnd128();
    wait_out(i, "b2b1", exp_lat(i, 1'b0), model(d1, 1'b0));
    @(posedge clk);
    #1;
    chk("b2b_end_valid", 128'(ov[i]), 128'(0));
  endtask
  localparam logic [127:0] KAT_IN  = 128'h8e4da1bc_01010101_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] KAT_OUT = 128'hdb135345_01010101_d4d4d4d5_2d26314c;
  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; byp[i] = 1'b0; ordy[i] = 1'b0; sin[i] = 128'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", 128'(ov[i]), 128'(0));
      chk("rst_busy", 128'(bsy[i]), 128'(0));
      chk("rst_in_ready", 128'(ir[i]), 128'(1));
      chk("rst_state_out", sout[i], 128'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      txn(i, KAT_IN, 1'b0, 0, KAT_OUT, "kat");
      txn(i, KAT_IN, 1'b1, 0, KAT_IN, "kat_bypass");
    end
    txn(0, KAT_IN, 1'b0, 10, KAT_OUT, "backpressure");
    @(negedge clk);
    iv[0] = 1'b1; sin[0] = rnd128(); byp[0] = 1'b0; ordy[0] = 1'b1;
    wait_ready(0, "abort");
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_busy", 128'(bsy[0]), 128'(0));
    chk("abort_in_ready", 128'(ir[0]), 128'(1));
    for (int n = 0; n < 5; n++) begin
      chk("abort_no_valid", 128'(ov[0]), 128'(0));
      @(posedge clk);
      #1;
    end
    txn(0, {4{32'hc6c6c6c6}}, 1'b0, 0, {4{32'hc6c6c6c6}}, "after_abort");
    for (int i = 0; i < 3; i++) b2b(i, rnd128(), rnd128());
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 15; n++) begin
        logic [127:0] d;
        logic bp;
        d  = rnd128();
        bp = ($urandom_range(0, 3) == 0);
        txn(i, d, bp, int'($urandom_range(0, 2)), model(d, bp), "random");
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
